td4_prog_loader: RTL and testbench

TD4_PROG_LOADER -- requirements
Module: td4_prog_loader

---
 rtl/td4_pkg.sv | 45 ++++
 rtl/td4_prog_mem.sv | 54 +++++
 rtl/td4_prog_loader.sv | 181 ++++++++++++++++++
 tb/tb_td4_prog_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// ============================================================================
// td4_pkg -- shared definitions for the TD4 program loader.
//
// Holds the program-memory geometry, the TD4 opcode constants and the loader
// FSM state encoding. The optional checksum stage is selected with the macro
// TD4_LOADER_CKSUM_EN; when it is undefined the CKSUM and ERROR states do not
// exist in the enumeration at all.
// ============================================================================
package td4_pkg;

    localparam int TD4_DEPTH  = 16;   // program words, one per 4-bit ip value
    localparam int TD4_WORD_W = 8;    // {OP[3:0], Imm[3:0]}
    localparam int TD4_ADDR_W = 4;

    // TD4 opcodes (upper nibble of an instruction word)
    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC_IM   = 4'b1110;
    localparam logic [3:0] OP_JMP_IM   = 4'b1111;

    // Encodings are fixed so the debug view is identical in both builds.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
`ifdef TD4_LOADER_CKSUM_EN
        S_CKSUM = 3'd2,
        S_ERROR = 3'd4,
`endif
        S_RUN   = 3'd3
    } td4_state_e;

    // Split an instruction word into its opcode field.
    function automatic logic [3:0] td4_opcode(input logic [TD4_WORD_W-1:0] word);
        return word[7:4];
    endfunction

endpackage

// File: rtl/td4_prog_mem.sv
// ============================================================================
// td4_prog_mem -- 16x8 TD4 program memory.
//
// Register array with asynchronous clear (active-low reset), one synchronous
// write port and one combinational read port.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   async active-low; clears every word to zero
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
// ============================================================================
module td4_prog_mem
    import td4_pkg::*;
#(
    parameter int DEPTH  = TD4_DEPTH,
    parameter int WORD_W = TD4_WORD_W,
    parameter int ADDR_W = TD4_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// ============================================================================
// td4_prog_loader -- writer side of the TD4 CPU program memory.
//
// After a start pulse the loader accepts 16 program bytes into addresses
// 0..15 while holding the CPU in reset, then releases the CPU. With the macro
// TD4_LOADER_CKSUM_EN defined a 17th checksum byte follows; the load is
// accepted only if the byte sum of all 17 bytes is 0 mod 256, otherwise the
// loader parks in ERROR with err=1 and keeps the CPU held.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   async active-low reset (clears FSM and memory)
//   start       in   one-cycle pulse, begin a program load (IDLE/RUN/ERROR)
//   byte_in     in   program byte
//   byte_valid  in   byte_in is valid
//   byte_ready  out  loader accepts a byte this cycle
//   ip          in   CPU instruction pointer
//   instr       out  mem[ip], combinational
//   cpu_hold    out  keep the CPU in reset (0 only in RUN)
//   load_addr   out  next write address
//   err         out  checksum failure (tied 0 without the checksum stage)
//   state_dbg   out  current FSM state, for observation only
// ============================================================================
module td4_prog_loader
    import td4_pkg::*;
#(
    parameter int DEPTH  = TD4_DEPTH,
    parameter int WORD_W = TD4_WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [3:0]        ip,
    output logic [WORD_W-1:0] instr,
    output logic              cpu_hold,
    output logic [3:0]        load_addr,
    output logic              err,
    output td4_state_e        state_dbg
);

    localparam int ADDR_W = TD4_ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Handshake: a byte is transferred on a rising edge exactly when
    // byte_valid and byte_ready are both 1. byte_ready depends only on the
    // state (LOAD or CKSUM), never on byte_valid, so inside those states
    // byte_valid alone identifies a transfer. byte_valid while byte_ready=0 is
    // dropped, and start is ignored while bytes are being accepted.

    td4_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we;

`ifdef TD4_LOADER_CKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] cksum_total;

    assign cksum_total = sum_q + byte_in;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_we     = 1'b0;
        byte_ready = 1'b0;
        cpu_hold   = 1'b1;
`ifdef TD4_LOADER_CKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
`ifdef TD4_LOADER_CKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    mem_we = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);   // wraps to 0 after 15
`ifdef TD4_LOADER_CKSUM_EN
                    sum_d  = sum_q + byte_in;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_CKSUM;
                    end
`else
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_RUN;
                    end
`endif
                end
            end
`ifdef TD4_LOADER_CKSUM_EN
            S_CKSUM: begin
                // The checksum byte is consumed but never written to memory.
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (cksum_total == '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                end
            end
`endif
            S_RUN: begin
                cpu_hold = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
`ifdef TD4_LOADER_CKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
`ifdef TD4_LOADER_CKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
`ifdef TD4_LOADER_CKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef TD4_LOADER_CKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign load_addr = addr_q;
    assign state_dbg = state_q;

    td4_prog_mem #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (byte_in),
        .raddr (ip),
        .rdata (instr)
    );

endmodule

// File: tb/tb_td4_prog_loader.sv
// ============================================================================
// tb_td4_prog_loader -- self-checking bench for td4_prog_loader.
//
// Stimulus pushes expected observations into a queue while driving inputs
// just after a rising edge; a monitor on the falling edge pops and compares
// them. Build with TD4_LOADER_CKSUM_EN to also exercise the checksum stage.
// ============================================================================
module tb_td4_prog_loader;
    import td4_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [3:0] ip = 4'h0;
    logic       byte_ready;
    logic [7:0] instr;
    logic       cpu_hold;
    logic [3:0] load_addr;
    logic       err;
    td4_state_e state_dbg;

    // ------------------------------------------------------------ clock/reset
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    td4_prog_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ip         (ip),
        .instr      (instr),
        .cpu_hold   (cpu_hold),
        .load_addr  (load_addr),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // ------------------------------------------------------------ scoreboard
    typedef enum int {K_INSTR, K_HOLD, K_READY, K_ADDR, K_ERR, K_STATE, K_XFER} kind_e;

    kind_e      kind_q[$];
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] tb_sum   = 8'h00;

    always @(negedge clock) begin : monitor
        kind_e      k;
        logic [7:0] e;
        logic [7:0] act;
        string      nm;
        logic       saw_xfer;
        saw_xfer = 1'b0;
        while (kind_q.size() > 0) begin
            k  = kind_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (k)
                K_INSTR: act = instr;
                K_HOLD:  act = {7'b0, cpu_hold};
                K_READY: act = {7'b0, byte_ready};
                K_ADDR:  act = {4'b0, load_addr};
                K_ERR:   act = {7'b0, err};
                K_STATE: act = {5'b0, state_dbg};
                default: begin
                    act      = {3'b0, byte_valid & byte_ready, load_addr};
                    saw_xfer = 1'b1;
                end
            endcase
            n_checks++;
            if (act !== e) begin
                n_errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, e);
            end
        end
        // Any valid byte not announced by the stimulus must not be accepted.
        if (byte_valid && !saw_xfer) begin
            n_checks++;
            if (byte_ready) begin
                n_errors++;
                $display("FAIL no_xfer: got byte_ready=1 at load_addr=%0d, expected 0", load_addr);
            end
        end
    end

    // ------------------------------------------------------------ driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_v(input kind_e k, input logic [7:0] v, input string nm);
        kind_q.push_back(k);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Start a load from IDLE/RUN/ERROR and expect LOAD at address 0.
    task automatic start_load();
        pulse_start();
        tb_sum = 8'h00;
        expect_v(K_STATE, 8'(S_LOAD), "state_after_start");
        expect_v(K_ADDR, 8'h00, "addr_after_start");
        expect_v(K_HOLD, 8'h01, "hold_in_load");
    endtask

    // One cycle with byte_valid=1, expected to transfer at address a.
    task automatic send(input logic [7:0] b, input logic [3:0] a);
        byte_in    = b;
        byte_valid = 1'b1;
        expect_v(K_XFER, {4'b0001, a}, $sformatf("xfer@%0d", a));
        tb_sum = tb_sum + b;
        tick();
        byte_valid = 1'b0;
    endtask

    // Completes a load: appends a correct checksum byte when that stage exists.
    task automatic finish_load();
`ifdef TD4_LOADER_CKSUM_EN
        expect_v(K_STATE, 8'(S_CKSUM), "state_cksum");
        send(8'h00 - tb_sum, 4'h0);
`endif
    endtask

    task automatic chk_mem(input logic [3:0] a, input logic [7:0] v);
        ip = a;
        expect_v(K_INSTR, v, $sformatf("instr[%0d]", a));
        tick();
    endtask

    task automatic expect_run();
        expect_v(K_STATE, 8'(S_RUN), "state_run");
        expect_v(K_HOLD, 8'h00, "hold_run");
        expect_v(K_READY, 8'h00, "ready_run");
        expect_v(K_ERR, 8'h00, "err_run");
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        #2 reset = 1'b0;
        tick();

        // Reset state
        expect_v(K_STATE, 8'(S_IDLE), "reset_state");
        expect_v(K_HOLD, 8'h01, "reset_hold");
        expect_v(K_READY, 8'h00, "reset_ready");
        expect_v(K_ADDR, 8'h00, "reset_addr");
        expect_v(K_ERR, 8'h00, "reset_err");
        chk_mem(4'd0, 8'h00);
        chk_mem(4'd15, 8'h00);
        reset = 1'b1;
        expect_v(K_STATE, 8'(S_IDLE), "idle_after_reset");
        tick();

        // Full load 01..10 with byte_valid held high
        start_load();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) expect_v(K_HOLD, 8'h01, "hold_at_last_xfer");
            send(8'(i + 1), 4'(i));
        end
        finish_load();
        expect_run();
        expect_v(K_ADDR, 8'h00, "addr_wrapped");
        chk_mem(4'd5, 8'h06);
        chk_mem(4'd0, 8'h01);
        chk_mem(4'd15, 8'h10);

        // Start in RUN: CPU held again, old contents still readable
        start_load();
        chk_mem(4'd5, 8'h06);

        // byte_valid toggled every other cycle; garbage on idle cycles
        for (int k = 0; k < 16; k++) begin
            send(8'hA0 + 8'(k), 4'(k));
            byte_in = 8'hEE;
            expect_v(K_ADDR, 8'((k + 1) % 16), "addr_hold_invalid");
            tick();
        end
        finish_load();
        expect_run();
        for (int k = 0; k < 16; k++) begin
            chk_mem(4'(k), 8'hA0 + 8'(k));
        end

        // byte_valid while byte_ready=0 is ignored
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        tick();
        tick();
        byte_valid = 1'b0;
        chk_mem(4'd0, 8'hA0);

        // start during LOAD ignored, alone and coincident with a transfer
        start_load();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                start = 1'b1;
                expect_v(K_STATE, 8'(S_LOAD), "start_ignored_state");
                tick();
                start = 1'b0;
            end
            if (i == 9) start = 1'b1;
            send(8'h30 + 8'(i), 4'(i));
            start = 1'b0;
        end
        finish_load();
        expect_run();
        chk_mem(4'd9, 8'h39);
        chk_mem(4'd15, 8'h3F);

        // Partial load, then reset mid-load
        start_load();
        for (int i = 0; i < 7; i++) begin
            send(8'hC0 + 8'(i), 4'(i));
        end
        expect_v(K_ADDR, 8'h07, "partial_addr");
        chk_mem(4'd6, 8'hC6);
        chk_mem(4'd3, 8'hC3);
        chk_mem(4'd10, 8'h3A);
        reset = 1'b0;
        expect_v(K_STATE, 8'(S_IDLE), "midload_reset_state");
        expect_v(K_ADDR, 8'h00, "midload_reset_addr");
        expect_v(K_HOLD, 8'h01, "midload_reset_hold");
        expect_v(K_READY, 8'h00, "midload_reset_ready");
        chk_mem(4'd6, 8'h00);
        chk_mem(4'd0, 8'h00);
        chk_mem(4'd10, 8'h00);
        reset = 1'b1;
        tick();
        start_load();
        for (int i = 0; i < 16; i++) begin
            send(8'h80 | 8'(i), 4'(i));
        end
        finish_load();
        expect_run();
        chk_mem(4'd0, 8'h80);
        chk_mem(4'd6, 8'h86);

`ifdef TD4_LOADER_CKSUM_EN
        // Bad checksum: 01..10 sums to 88, so 77 leaves FF
        start_load();
        for (int i = 0; i < 16; i++) begin
            send(8'(i + 1), 4'(i));
        end
        expect_v(K_STATE, 8'(S_CKSUM), "state_cksum_bad");
        send(8'h77, 4'h0);
        expect_v(K_STATE, 8'(S_ERROR), "state_error");
        expect_v(K_ERR, 8'h01, "err_set");
        expect_v(K_HOLD, 8'h01, "hold_error");
        expect_v(K_READY, 8'h00, "ready_error");
        chk_mem(4'd0, 8'h01);
        start_load();
        expect_v(K_ERR, 8'h00, "err_cleared");
        tick();
`endif

        tick();
        tick();
        n_checks++;
        if (kind_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", kind_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
